pixel_mapper: RTL and testbench

- Parametrised scan-and-map engine. Walks every pixel of an H_RES x V_RES frame in raster order and maps each (x, y) to a signed fixed-point point c = c_re + j*c_im on the complex plane: c_re = re_origin + x*delta_x, c_im = im_origin + y*delta_y.
- Streams results to the iteration core over a valid/ready handshake, with a pipelined multiply, backpressure stall, per-sample saturation/overflow flags, abort, and a frame-done pulse.
- Sits between the configuration registers and the Mandelbrot iteration engine.

---
 rtl/pixel_mapper.sv | 227 ++++++++++++++++++++++
 tb/tb_pixel_mapper.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_mapper.sv
// pixel_mapper: raster-scan coordinate generator for the Mandelbrot engine.
// Walks an H_RES x V_RES frame in raster order and maps each pixel (x, y) to
// a signed fixed-point point c_re = re_origin + x*delta_x,
// c_im = im_origin + y*delta_y. Results leave through a valid/ready stream.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a frame (sampled only in IDLE)
//   abort                    flush the pipeline and return to IDLE
//   delta_x/delta_y          signed per-pixel / per-line steps (latched at start)
//   re_origin/im_origin      signed value at x=0 / y=0 (latched at start)
//   out_valid/out_ready      output handshake
//   c_re/c_im                mapped point, saturated to DATA_W
//   px_x/px_y                pixel coordinate of the sample
//   sat                      this sample was saturated
//   ovf                      sticky: a saturated sample was accepted this frame
//   busy                     high outside IDLE
//   frame_done               one-cycle pulse when the last sample is accepted
module pixel_mapper #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 21,
  parameter int MUL_LAT = 2,
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] delta_x,
  input  logic [DATA_W-1:0] delta_y,
  input  logic [DATA_W-1:0] re_origin,
  input  logic [DATA_W-1:0] im_origin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] c_re,
  output logic [DATA_W-1:0] c_im,
  output logic [XW-1:0]     px_x,
  output logic [YW-1:0]     px_y,
  output logic              sat,
  output logic              ovf,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW     = (XW > YW) ? XW : YW;
  localparam int PW     = DATA_W + CW + 1;       // full-width product
  localparam int SW     = PW + 1;                // full-width sum
  localparam int INT_W  = DATA_W - 1 - FRAC_W;   // integer bits of Q(INT_W).FRAC_W
  localparam int SIGN_B = INT_W + FRAC_W;        // sign bit position of a DATA_W value

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic                      ovf_q, ovf_d;
  logic                      load_cfg;
  logic                      done_c;
  logic signed [DATA_W-1:0]  dx_q, dy_q, reo_q, imo_q;

  logic [MUL_LAT-1:0]        vld_p;
  logic signed [PW-1:0]      mul_re_p [MUL_LAT];
  logic signed [PW-1:0]      mul_im_p [MUL_LAT];
  logic [XW-1:0]             px_p     [MUL_LAT];
  logic [YW-1:0]             py_p     [MUL_LAT];

  logic                      out_valid_q, sat_q;
  logic signed [DATA_W-1:0]  cre_q, cim_q;
  logic [XW-1:0]             pxo_q;
  logic [YW-1:0]             pyo_q;

  logic                      advance, accept, issue, last_out;
  logic [DATA_W:0]           res_re, res_im;

  // Add origin to product at full width, then clamp; MSB of result is the flag.
  function automatic logic [DATA_W:0] sat_add(input logic signed [DATA_W-1:0] org,
                                              input logic signed [PW-1:0]     prod);
    logic signed [SW-1:0] sum;
    sum = SW'(org) + SW'(prod);
    if (sum[SW-1:SIGN_B] == {(SW-SIGN_B){sum[SW-1]}})
      return {1'b0, sum[DATA_W-1:0]};
    else if (sum[SW-1])
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  assign advance  = !out_valid_q || out_ready;
  assign accept   = out_valid_q && out_ready;
  assign issue    = (state_q == S_RUN) && advance && !abort;
  assign last_out = (pxo_q == XW'(H_RES-1)) && (pyo_q == YW'(V_RES-1));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    load_cfg = 1'b0;
    done_c   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      if (accept && sat_q) ovf_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_RUN;
            x_d      = '0;
            y_d      = '0;
            ovf_d    = 1'b0;
            load_cfg = 1'b1;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (x_q == XW'(H_RES-1)) begin
              x_d = '0;
              if (y_q == YW'(V_RES-1)) state_d = S_DRAIN;
              else                     y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Only one sample carries the last coordinate, so matching it is enough.
          if (accept && last_out) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      reo_q   <= '0;
      imo_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      if (load_cfg) begin
        dx_q  <= delta_x;
        dy_q  <= delta_y;
        reo_q <= re_origin;
        imo_q <= im_origin;
      end
    end
  end

  // ---- multiply stages p[0..MUL_LAT-1]: product formed at p[0], then delayed ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else if (abort) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p[0] <= issue;
      for (int k = 1; k < MUL_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      mul_re_p[0] <= $signed(PW'(x_q)) * PW'(dx_q);
      mul_im_p[0] <= $signed(PW'(y_q)) * PW'(dy_q);
      px_p[0]     <= x_q;
      py_p[0]     <= y_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        mul_re_p[k] <= mul_re_p[k-1];
        mul_im_p[k] <= mul_im_p[k-1];
        px_p[k]     <= px_p[k-1];
        py_p[k]     <= py_p[k-1];
      end
    end
  end

  // ---- add/saturate stage: output register ----
  assign res_re = sat_add(reo_q, mul_re_p[MUL_LAT-1]);
  assign res_im = sat_add(imo_q, mul_im_p[MUL_LAT-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      cre_q       <= '0;
      cim_q       <= '0;
      pxo_q       <= '0;
      pyo_q       <= '0;
      sat_q       <= 1'b0;
    end else if (abort) begin
      out_valid_q <= 1'b0;
    end else if (advance) begin
      out_valid_q <= vld_p[MUL_LAT-1];
      if (vld_p[MUL_LAT-1]) begin
        cre_q <= res_re[DATA_W-1:0];
        cim_q <= res_im[DATA_W-1:0];
        pxo_q <= px_p[MUL_LAT-1];
        pyo_q <= py_p[MUL_LAT-1];
        sat_q <= res_re[DATA_W] | res_im[DATA_W];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign c_re       = cre_q;
  assign c_im       = cim_q;
  assign px_x       = pxo_q;
  assign px_y       = pyo_q;
  assign sat        = sat_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_c;

endmodule

// File: tb/tb_pixel_mapper.sv
// Directed bench for pixel_mapper on a 4x3 frame, Q10.21 values, MUL_LAT=2.
module tb_pixel_mapper;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [31:0] delta_x, delta_y, re_origin, im_origin;
  logic        out_valid, sat, ovf, busy, frame_done;
  logic [31:0] c_re, c_im;
  logic [1:0]  px_x, px_y;

  int n_cmp = 0;
  int n_mis = 0;

  pixel_mapper #(.H_RES(4), .V_RES(3), .DATA_W(32), .FRAC_W(21), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delta_x(delta_x), .delta_y(delta_y), .re_origin(re_origin), .im_origin(im_origin),
    .out_valid(out_valid), .out_ready(out_ready), .c_re(c_re), .c_im(c_im),
    .px_x(px_x), .px_y(px_y), .sat(sat), .ovf(ovf), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: origin + idx*delta at 64 bits, clamped to 32-bit signed.
  function automatic logic [32:0] mdl(input logic [31:0] org, input logic [31:0] d, input int idx);
    longint s;
    longint mx;
    longint mn;
    mx = 64'sd2147483647;
    mn = -mx - 1;
    s  = longint'($signed(org)) + longint'(idx) * longint'($signed(d));
    if (s > mx)      return {1'b1, 32'h7FFFFFFF};
    else if (s < mn) return {1'b1, 32'h80000000};
    else             return {1'b0, s[31:0]};
  endfunction

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1 repeating.
  task automatic run_frame(input int mode, input bit scramble,
                           input logic [31:0] dx, input logic [31:0] dy,
                           input logic [31:0] reo, input logic [31:0] imo,
                           input int pk, input logic [31:0] p_re,
                           input logic [31:0] p_im, input logic p_sat);
    int k, cyc, first_cyc, last_cyc;
    bit hold, exp_ovf;
    logic [31:0] h_re, h_im;
    logic [1:0]  h_x, h_y;
    logic        h_sat;
    logic [32:0] er, ei;
    logic [3:0]  pat;
    pat = 4'b1001;
    delta_x = dx; delta_y = dy; re_origin = reo; im_origin = imo;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      delta_x = 32'h1234_5678; delta_y = 32'h8765_4321;
      re_origin = 32'h0F0F_0F0F; im_origin = 32'hF0F0_F0F0;
    end
    chk("busy_run", busy, 1'b1);
    chk("ovf_clear_on_start", ovf, 1'b0);
    k = 0; cyc = 0; first_cyc = -1; last_cyc = -1; hold = 0; exp_ovf = 0;
    while (k < 12 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
      #1;
      if (hold) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", {c_re, c_im}, {h_re, h_im});
        chk("stall_hold_px", {h_x, h_y, h_sat}, {px_x, px_y, sat});
        hold = 0;
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && out_ready) begin
        er = mdl(reo, dx, k % 4);
        ei = mdl(imo, dy, k / 4);
        chk("px_x", px_x, k % 4);
        chk("px_y", px_y, k / 4);
        chk("c_re", c_re, er[31:0]);
        chk("c_im", c_im, ei[31:0]);
        chk("sat", sat, er[32] | ei[32]);
        chk("frame_done_at_accept", frame_done, k == 11);
        if (k == pk) begin
          chk("probe_c_re", c_re, p_re);
          chk("probe_c_im", c_im, p_im);
          chk("probe_sat", sat, p_sat);
        end
        exp_ovf = exp_ovf | er[32] | ei[32];
        last_cyc = cyc;
        k++;
      end else begin
        chk("frame_done_idle", frame_done, 1'b0);
        if (out_valid) begin
          hold = 1; h_re = c_re; h_im = c_im; h_x = px_x; h_y = px_y; h_sat = sat;
        end
      end
      tick();
      cyc++;
    end
    chk("frame_count", k, 12);
    chk("busy_after_done", busy, 1'b0);
    chk("valid_after_done", out_valid, 1'b0);
    chk("ovf_frame", ovf, exp_ovf);
    if (mode == 0) begin
      chk("first_latency", first_cyc, 3);
      chk("no_bubbles", last_cyc, 14);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    delta_x = '0; delta_y = '0; re_origin = '0; im_origin = '0;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_c_re", c_re, 32'h0);
    chk("rst_c_im", c_im, 32'h0);
    chk("rst_px", {px_x, px_y}, 4'h0);
    chk("rst_flags", {sat, ovf, busy, frame_done}, 4'h0);
    rst = 1'b0;
    tick();

    // 1: plain frame, unit steps, origin 0
    run_frame(0, 0, 32'h0020_0000, 32'h0020_0000, 32'h0, 32'h0,
              11, 32'h0060_0000, 32'h0040_0000, 1'b0);

    // 2: backpressure 1,0,0,1 with configuration inputs changed mid-frame
    run_frame(1, 1, 32'h0020_0000, 32'h0020_0000, 32'h0, 32'h0,
              5, 32'h0020_0000, 32'h0020_0000, 1'b0);

    // 3: positive saturation from x=1, then a fresh start clears ovf
    run_frame(0, 0, 32'h0020_0000, 32'h0020_0000, 32'h7FF0_0000, 32'h0,
              1, 32'h7FFF_FFFF, 32'h0, 1'b1);
    chk("ovf_sticky", ovf, 1'b1);
    run_frame(0, 0, 32'h0020_0000, 32'h0020_0000, 32'h0, 32'h0,
              0, 32'h0, 32'h0, 1'b0);

    // 4: negative step from a negative origin
    run_frame(0, 0, 32'hFFE0_0000, 32'h0020_0000, 32'hC000_0000, 32'h0,
              3, 32'hBFA0_0000, 32'h0, 1'b0);

    // 5: abort together with start, five cycles into a frame
    delta_x = 32'h0020_0000; delta_y = 32'h0020_0000; re_origin = '0; im_origin = '0;
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    abort = 1'b1; start = 1'b1;
    #1;
    chk("abort_cycle_done", frame_done, 1'b0);
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (4) begin
      tick();
      chk("abort_flushed", {out_valid, frame_done, busy}, 3'b000);
    end
    run_frame(0, 0, 32'h0020_0000, 32'h0020_0000, 32'h0, 32'h0,
              11, 32'h0060_0000, 32'h0040_0000, 1'b0);

    // 6: asynchronous reset between clock edges, mid-frame
    delta_x = 32'h0020_0000; delta_y = 32'h0020_0000;
    re_origin = 32'h7FF0_0000; im_origin = '0;
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_rst_ovf", ovf, 1'b1);
    chk("pre_rst_c_re", c_re, 32'h7FF0_0000);
    chk("pre_rst_c_im", c_im, 32'h0020_0000);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_data", {c_re, c_im}, 64'h0);
    chk("arst_px", {px_x, px_y}, 4'h0);
    chk("arst_flags", {sat, ovf, busy, frame_done}, 4'h0);
    tick();
    #2;
    rst = 1'b0;
    repeat (6) begin
      tick();
      chk("post_rst_quiet", {out_valid, frame_done, busy}, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
